// File: rtl/spw_tcr_pkg.sv
// Shared definitions for the SpwTCR host-side TX packet multiplexer.
//   - spw_nchar_t : 9-bit N-Char, bit 8 set marks a control character
//   - SPW_EOP / SPW_EEP : end-of-packet and error-end-of-packet codes
//   - IDLE / FWD / DRAIN : multiplexer FSM state encodings
package spw_tcr_pkg;

  typedef logic [8:0] spw_nchar_t;

  localparam spw_nchar_t SPW_EOP = 9'h100;
  localparam spw_nchar_t SPW_EEP = 9'h101;

  typedef logic [1:0] mux_state_t;

  localparam mux_state_t IDLE  = 2'd0;
  localparam mux_state_t FWD   = 2'd1;
  localparam mux_state_t DRAIN = 2'd2;

endpackage

// File: rtl/spw_tcr_ch_fifo.sv
// Per-channel first-word-fall-through FIFO of 9-bit N-Chars.
// Ports:
//   clk, rst        : clock and asynchronous active-high reset
//   wr_en, wr_data  : write strobe and N-Char; writes while full are dropped
//   rd_en, rd_data  : pop strobe and head word (valid whenever !empty)
//   full, empty     : occupancy flags
module spw_tcr_ch_fifo
  import spw_tcr_pkg::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_en,
  input  spw_nchar_t wr_data,
  input  logic       rd_en,
  output spw_nchar_t rd_data,
  output logic       full,
  output logic       empty
);

  localparam int unsigned PtrW = $clog2(DEPTH);

  spw_nchar_t      mem_q [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]   count_q;
  logic            do_wr, do_rd;

  assign full    = (count_q == (PtrW + 1)'(DEPTH));
  assign empty   = (count_q == '0);
  // A write while full is dropped even if a pop frees a slot this cycle.
  assign do_wr   = wr_en && !full;
  assign do_rd   = rd_en && !empty;
  assign rd_data = mem_q[rd_ptr_q];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      // DEPTH is a power of two, so natural pointer overflow is the wrap.
      if (do_wr) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (do_rd) rd_ptr_q <= rd_ptr_q + PtrW'(1);
      unique case ({do_wr, do_rd})
        2'b10:   count_q <= count_q + (PtrW + 1)'(1);
        2'b01:   count_q <= count_q - (PtrW + 1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/spw_tcr_pkt_mux.sv
// N-channel packet-aware TX multiplexer in front of the SpwTCR codec.
// Each channel owns a FWFT FIFO; a round-robin arbiter grants one channel and
// forwards its whole packet (through EOP/EEP) before re-arbitrating.
// Optional feature macro: SPW_PKT_MUX_TIMEOUT_EN (stall timeout, EEP insert,
// drain of the aborted packet remainder).
// Ports:
//   CLOCK, RESET        : clock and asynchronous active-high reset
//   CH_DATA_I, CH_WR    : per-channel N-Char (channel k at [9k+8:9k]) and strobe
//   CH_FULL, CH_EMPTY   : per-channel FIFO flags
//   DATA_O, WR_DATA_O   : N-Char and write strobe to codec
//   TX_FULL_I           : codec back-pressure
//   GRANT_O             : one-hot current grant, 0 when idle
//   CH_ABORT_O          : one-cycle abort pulse per channel (0 without option)
module spw_tcr_pkt_mux
  import spw_tcr_pkg::*;
#(
  parameter int unsigned N_CH    = 4,
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic              CLOCK,
  input  logic              RESET,
  input  logic [N_CH*9-1:0] CH_DATA_I,
  input  logic [N_CH-1:0]   CH_WR,
  output logic [N_CH-1:0]   CH_FULL,
  output logic [N_CH-1:0]   CH_EMPTY,
  output logic [8:0]        DATA_O,
  output logic              WR_DATA_O,
  input  logic              TX_FULL_I,
  output logic [N_CH-1:0]   GRANT_O,
  output logic [N_CH-1:0]   CH_ABORT_O
);

  localparam int unsigned IdxW = $clog2(N_CH);

  if (N_CH < 2 || N_CH > 8 || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT < 1)
  begin : g_bad_param
    $error("spw_tcr_pkt_mux: illegal parameter set");
  end

  mux_state_t      state_q, state_d;
  logic [IdxW-1:0] gnt_q, gnt_d;
  logic [IdxW-1:0] last_q, last_d;
  spw_nchar_t      data_q, data_out;
  logic            wr_out;

  spw_nchar_t      fifo_dout [N_CH];
  logic [N_CH-1:0] fifo_full, fifo_empty, fifo_pop;
  spw_nchar_t      head;
  logic            head_empty;

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    spw_tcr_ch_fifo #(
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk     (CLOCK),
      .rst     (RESET),
      .wr_en   (CH_WR[k]),
      .wr_data (CH_DATA_I[9*k +: 9]),
      .rd_en   (fifo_pop[k]),
      .rd_data (fifo_dout[k]),
      .full    (fifo_full[k]),
      .empty   (fifo_empty[k])
    );
  end

  assign CH_FULL    = fifo_full;
  assign CH_EMPTY   = fifo_empty;
  assign head       = fifo_dout[gnt_q];
  assign head_empty = fifo_empty[gnt_q];

  // Round-robin search starting one past the last channel served.
  logic            pick_vld;
  logic [IdxW-1:0] pick_idx;
  int unsigned     cand;
  logic [IdxW-1:0] cand_idx;

  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    cand     = 0;
    cand_idx = '0;
    for (int unsigned i = 1; i <= N_CH; i++) begin
      cand     = (32'(last_q) + i) % N_CH;
      cand_idx = IdxW'(cand);
      if (!pick_vld && !fifo_empty[cand_idx]) begin
        pick_vld = 1'b1;
        pick_idx = cand_idx;
      end
    end
  end

`ifdef SPW_PKT_MUX_TIMEOUT_EN
  localparam int unsigned StallW = $clog2(TIMEOUT + 1);

  logic [StallW-1:0] stall_q, stall_d;
  logic [N_CH-1:0]   abort;
`endif

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    last_d   = last_q;
    wr_out   = 1'b0;
    data_out = data_q;
    fifo_pop = '0;
`ifdef SPW_PKT_MUX_TIMEOUT_EN
    stall_d  = stall_q;
    abort    = '0;
`endif
    case (state_q)
      IDLE: begin
        // Grant cycle only; data starts moving the cycle after.
        if (pick_vld) begin
          gnt_d   = pick_idx;
          state_d = FWD;
        end
`ifdef SPW_PKT_MUX_TIMEOUT_EN
        stall_d = '0;
`endif
      end
      FWD: begin
        data_out = head;
        if (!head_empty && !TX_FULL_I) begin
          wr_out          = 1'b1;
          fifo_pop[gnt_q] = 1'b1;
          if (head[8]) begin
            last_d  = gnt_q;
            state_d = IDLE;
          end
        end
`ifdef SPW_PKT_MUX_TIMEOUT_EN
        if (stall_q == StallW'(TIMEOUT)) begin
          // Terminate the stalled packet with EEP as soon as the codec accepts.
          data_out     = SPW_EEP;
          wr_out       = !TX_FULL_I;
          fifo_pop     = '0;
          abort[gnt_q] = !TX_FULL_I;
          last_d       = last_q;
          state_d      = TX_FULL_I ? FWD : DRAIN;
        end else if (wr_out) begin
          stall_d = '0;
        end else if (head_empty && !TX_FULL_I) begin
          stall_d = stall_q + StallW'(1);
        end
`endif
      end
`ifdef SPW_PKT_MUX_TIMEOUT_EN
      DRAIN: begin
        // Discard the rest of the aborted packet; the grant stays held.
        if (!head_empty) begin
          fifo_pop[gnt_q] = 1'b1;
          if (head[8]) begin
            last_d  = gnt_q;
            state_d = IDLE;
          end
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      last_q  <= IdxW'(N_CH - 1);
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      data_q  <= data_out;
    end
  end

`ifdef SPW_PKT_MUX_TIMEOUT_EN
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign CH_ABORT_O = abort;
`else
  assign CH_ABORT_O = '0;
`endif

  always_comb begin
    GRANT_O = '0;
    if (state_q != IDLE) GRANT_O[gnt_q] = 1'b1;
  end

  assign DATA_O    = data_out;
  assign WR_DATA_O = wr_out;

endmodule

// File: tb/tb_spw_tcr_pkt_mux.sv
module tb_spw_tcr_pkt_mux;
  import spw_tcr_pkg::*;

  localparam int N_CH    = 4;
  localparam int DEPTH   = 16;
  localparam int TIMEOUT = 8;

  logic              CLOCK;
  logic              RESET;
  logic [N_CH*9-1:0] CH_DATA_I;
  logic [N_CH-1:0]   CH_WR;
  logic [N_CH-1:0]   CH_FULL;
  logic [N_CH-1:0]   CH_EMPTY;
  logic [8:0]        DATA_O;
  logic              WR_DATA_O;
  logic              TX_FULL_I;
  logic [N_CH-1:0]   GRANT_O;
  logic [N_CH-1:0]   CH_ABORT_O;

  spw_tcr_pkt_mux #(
    .N_CH    (N_CH),
    .DEPTH   (DEPTH),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .CLOCK      (CLOCK),
    .RESET      (RESET),
    .CH_DATA_I  (CH_DATA_I),
    .CH_WR      (CH_WR),
    .CH_FULL    (CH_FULL),
    .CH_EMPTY   (CH_EMPTY),
    .DATA_O     (DATA_O),
    .WR_DATA_O  (WR_DATA_O),
    .TX_FULL_I  (TX_FULL_I),
    .GRANT_O    (GRANT_O),
    .CH_ABORT_O (CH_ABORT_O)
  );

  initial CLOCK = 1'b0;
  always #5 CLOCK = ~CLOCK;

  int cyc;
  always @(posedge CLOCK) cyc <= cyc + 1;

  int n_vec;
  int n_err;

  // Scoreboard: expected words per channel, in write order.
  typedef struct {
    int         ch;
    spw_nchar_t w;
  } exp_t;
  exp_t sb[$];

  int cur_ch = -1;        // channel whose packet is in flight (model)
  int m_last = N_CH - 1;  // model round-robin pointer
  int wr_cyc[$];          // cycles at which the codec saw a write
  int abort_cyc[$];
  logic [N_CH-1:0] abort_vec;

  typedef struct {
    int              ch;
    int              len;
    bit              toggle;
    logic [5:0][8:0] w;
  } vec_t;
  vec_t tbl [4];

  function automatic vec_t mkvec(int ch, int len, bit tg, spw_nchar_t a, spw_nchar_t b,
                                 spw_nchar_t c, spw_nchar_t d, spw_nchar_t e);
    vec_t v;
    v.ch = ch; v.len = len; v.toggle = tg;
    v.w = '0;
    v.w[0] = a; v.w[1] = b; v.w[2] = c; v.w[3] = d; v.w[4] = e;
    return v;
  endfunction

  task automatic check(string name, logic [31:0] got, logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  function automatic int find(int c);
    foreach (sb[i]) if (sb[i].ch == c) return i;
    return -1;
  endfunction

  // Output monitor, sampled on the falling edge.
  always @(negedge CLOCK) begin
    int idx;
    if (!RESET) begin
      if (TX_FULL_I) check("wr_under_full", 32'(WR_DATA_O), 0);
`ifdef SPW_PKT_MUX_TIMEOUT_EN
      if (CH_ABORT_O != '0) begin
        abort_vec = CH_ABORT_O;
        abort_cyc.push_back(cyc);
      end
`else
      if (WR_DATA_O) check("abort_tied_low", 32'(CH_ABORT_O), 0);
`endif
      if (WR_DATA_O) begin
        wr_cyc.push_back(cyc);
        if (cur_ch < 0) begin
          for (int i = 1; i <= N_CH; i++) begin
            int c;
            c = (m_last + i) % N_CH;
            if (cur_ch < 0 && find(c) >= 0) cur_ch = c;
          end
        end
        idx = (cur_ch < 0) ? -1 : find(cur_ch);
        if (idx < 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_write: got data 0x%0h grant 0x%0h, want no write (cycle %0d)",
                   DATA_O, GRANT_O, cyc);
        end else begin
          check("grant", 32'(GRANT_O), 32'(1) << cur_ch);
          check("data", 32'(DATA_O), 32'(sb[idx].w));
          if (sb[idx].w[8]) begin
            m_last = cur_ch;
            cur_ch = -1;
          end
          sb.delete(idx);
        end
      end
    end
  end

  task automatic put(int ch, spw_nchar_t w, bit push);
    exp_t e;
    CH_DATA_I[ch*9 +: 9] = w;
    CH_WR[ch] = 1'b1;
    if (push) begin
      e.ch = ch;
      e.w  = w;
      sb.push_back(e);
    end
  endtask

  task automatic step();
    @(posedge CLOCK);
    #1;
    CH_WR = '0;
  endtask

  task automatic wait_drain(int max_cyc, bit toggle);
    int n;
    n = 0;
    while ((sb.size() != 0 || cur_ch >= 0) && n < max_cyc) begin
      if (toggle) TX_FULL_I = ~TX_FULL_I;
      @(posedge CLOCK);
      #1;
      n++;
    end
    TX_FULL_I = 1'b0;
    check("drain_timeout", 32'(sb.size()), 0);
  endtask

  initial begin
    int w0cyc;
    spw_nchar_t w;

    RESET     = 1'b1;
    CH_WR     = '0;
    CH_DATA_I = '0;
    TX_FULL_I = 1'b0;
    n_vec     = 0;
    n_err     = 0;

    tbl[0] = mkvec(0, 3, 1'b0, 9'h0AA, 9'h0BB, SPW_EOP, 9'h000, 9'h000);
    tbl[1] = mkvec(3, 5, 1'b1, 9'h031, 9'h032, 9'h033, 9'h034, SPW_EEP);
    tbl[2] = mkvec(2, 1, 1'b0, SPW_EOP, 9'h000, 9'h000, 9'h000, 9'h000);
    tbl[3] = mkvec(1, 4, 1'b0, 9'h0C1, 9'h0C2, 9'h0C3, SPW_EEP, 9'h000);

    // Reset values.
    repeat (2) @(posedge CLOCK);
    @(negedge CLOCK);
    check("rst_empty", 32'(CH_EMPTY), 32'hF);
    check("rst_full", 32'(CH_FULL), 0);
    check("rst_grant", 32'(GRANT_O), 0);
    check("rst_wr", 32'(WR_DATA_O), 0);
    check("rst_data", 32'(DATA_O), 0);
    check("rst_abort", 32'(CH_ABORT_O), 0);
    @(posedge CLOCK);
    #1;
    RESET = 1'b0;
    step();

    // Single-packet vectors.
    for (int t = 0; t < 4; t++) begin
      wr_cyc.delete();
      if (tbl[t].toggle) TX_FULL_I = 1'b1;
      w0cyc = cyc;
      for (int j = 0; j < tbl[t].len; j++) begin
        put(tbl[t].ch, tbl[t].w[j], 1'b1);
        step();
      end
      wait_drain(60, tbl[t].toggle);
      check("vec_count", 32'(wr_cyc.size()), 32'(tbl[t].len));
      if (!tbl[t].toggle && wr_cyc.size() == tbl[t].len) begin
        check("vec_latency", 32'(wr_cyc[0] - w0cyc), 2);
        check("vec_span", 32'(wr_cyc[tbl[t].len - 1] - wr_cyc[0]), 32'(tbl[t].len - 1));
      end
      check("vec_idle_grant", 32'(GRANT_O), 0);
      check("vec_data_hold", 32'(DATA_O), 32'(tbl[t].w[tbl[t].len - 1]));
    end

    // Two channels loaded together: whole packets, one idle cycle between.
    wr_cyc.delete();
    put(1, 9'h011, 1'b1); put(2, 9'h021, 1'b1); step();
    put(1, 9'h012, 1'b1); put(2, 9'h022, 1'b1); step();
    put(1, SPW_EOP, 1'b1); put(2, SPW_EOP, 1'b1); step();
    wait_drain(60, 1'b0);
    check("t2_count", 32'(wr_cyc.size()), 6);
    if (wr_cyc.size() == 6) begin
      check("t2_contig_a", 32'(wr_cyc[2] - wr_cyc[0]), 2);
      check("t2_gap", 32'(wr_cyc[3] - wr_cyc[2]), 2);
      check("t2_contig_b", 32'(wr_cyc[5] - wr_cyc[3]), 2);
    end

    // Fill ch0 past depth under back-pressure; the 17th word is dropped.
    TX_FULL_I = 1'b1;
    for (int i = 0; i < DEPTH + 1; i++) begin
      w = (i == DEPTH - 1) ? SPW_EOP : (i == DEPTH) ? 9'h0EE : 9'(32'h40 + i);
      put(0, w, i < DEPTH);
      step();
      if (i == DEPTH - 2) check("t3_not_full", 32'(CH_FULL[0]), 0);
      if (i == DEPTH - 1) check("t3_full", 32'(CH_FULL[0]), 1);
    end
    check("t3_full_after_drop", 32'(CH_FULL[0]), 1);
    wr_cyc.delete();
    TX_FULL_I = 1'b0;
    wait_drain(60, 1'b0);
    check("t3_count", 32'(wr_cyc.size()), DEPTH);
    check("t3_empty", 32'(CH_EMPTY[0]), 1);
    check("t3_idle_grant", 32'(GRANT_O), 0);

`ifdef SPW_PKT_MUX_TIMEOUT_EN
    // Stalled packet: EEP insertion, abort pulse, drain of the remainder.
    wr_cyc.delete();
    abort_cyc.delete();
    abort_vec = '0;
    put(0, 9'h011, 1'b1);
    begin
      exp_t e;
      e.ch = 0;
      e.w  = SPW_EEP;
      sb.push_back(e);
    end
    step();
    wait_drain(60, 1'b0);
    check("t5_count", 32'(wr_cyc.size()), 2);
    if (wr_cyc.size() == 2) check("t5_timeout_gap", 32'(wr_cyc[1] - wr_cyc[0]), TIMEOUT + 1);
    check("t5_abort_count", 32'(abort_cyc.size()), 1);
    if (abort_cyc.size() == 1 && wr_cyc.size() == 2)
      check("t5_abort_cycle", 32'(abort_cyc[0]), 32'(wr_cyc[1]));
    check("t5_abort_vec", 32'(abort_vec), 32'h1);
    check("t5_grant_drain", 32'(GRANT_O), 32'h1);
    put(0, 9'h022, 1'b0); step();
    put(0, SPW_EOP, 1'b0); step();
    repeat (4) step();
    check("t5_idle_grant", 32'(GRANT_O), 0);
    check("t5_empty", 32'(CH_EMPTY[0]), 1);
`endif

    // Reset in the middle of a granted ch2 packet.
    TX_FULL_I = 1'b1;
    put(2, 9'h061, 1'b0); step();
    put(2, 9'h062, 1'b0); step();
    repeat (2) step();
    check("t6_grant_before", 32'(GRANT_O), 32'h4);
    RESET = 1'b1;
    @(negedge CLOCK);
    check("t6_wr", 32'(WR_DATA_O), 0);
    check("t6_grant", 32'(GRANT_O), 0);
    check("t6_empty", 32'(CH_EMPTY), 32'hF);
    check("t6_full", 32'(CH_FULL), 0);
    @(posedge CLOCK);
    #1;
    RESET     = 1'b0;
    TX_FULL_I = 1'b0;
    cur_ch    = -1;
    m_last    = N_CH - 1;
    sb.delete();
    step();

    // After reset, ch1 wins over ch3 (pointer restarts before ch0).
    wr_cyc.delete();
    put(3, 9'h0D3, 1'b1); put(1, 9'h0D1, 1'b1); step();
    put(3, SPW_EOP, 1'b1); put(1, SPW_EOP, 1'b1); step();
    wait_drain(60, 1'b0);
    check("t6_post_count", 32'(wr_cyc.size()), 4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
